pcileech_cfg_access_arbiter: RTL and testbench
==============================================

// Module: pcileech_cfg_access_arbiter
// PURPOSE
// - Arbitrates the single shared multi-function config-space memory port between two requesters:
//   - host CfgRd/CfgWr requests, already decoded from the 128-bit TLP stream;
//   - FPGA-side (USB/shadow) config accesses.
// - Runs exactly one access at a time.
// - Host requests get a completion record for the cfgspace TX block; USB accesses get a one-cycle response pulse.
// - Sits between the TLP decode and the multi-function memory wrapper.
// PARAMETERS
// - MEM_RD_LATENCY  2  cycles from mem_en (read) to mem_rdata valid; legal range 1..7
// - STARVE_LIMIT    4  consecutive host grants while usb_req_valid is high before USB is forced; range 1..15
// PORTS
// - clk_pcie          in   1   sole clock
// - rst_n             in   1   asynchronous, active-low reset
// - pcie_req_valid    in   1   host request valid
// - pcie_req_ready    out  1   host request accepted when valid & ready
// - pcie_req_wr       in   1   1 = CfgWr, 0 = CfgRd
// - pcie_req_func     in   3   target function number
// - pcie_req_addr     in   10  DWORD address
// - pcie_req_be       in   4   first-DW byte enables
// - pcie_req_data     in   32  write data
// - pcie_req_tag      in   8   TLP tag
// - pcie_req_reqid    in   16  requester ID
// - usb_req_valid/ready/wr/func/addr/be/data   in/out/in/in/in/in/in   1/1/1/3/10/4/32   USB request, same meaning as host fields
// - func_mask         in   8   bit n = 1: function n is implemented
// - mem_en            out  1   one-cycle memory strobe
// - mem_wr            out  1   write qualifier
// - mem_func          out  3   function number to memory
// - mem_addr          out  10  address to memory
// - mem_be            out  4   byte enables to memory
// - mem_wdata         out  32  write data to memory
// - mem_rdata         in   32  read data, valid MEM_RD_LATENCY cycles after mem_en
// - cpl_valid         out  1   completion valid
// - cpl_ready         in   1   completion consumed when valid & ready
// - cpl_status        out  3   000 = SC, 001 = UR
// - cpl_tlpwr         out  1   completion belongs to a CfgWr
// - cpl_tag           out  8   completion tag
// - cpl_reqid         out  16  completion requester ID
// - cpl_data          out  32  completion data
// - usb_rsp_valid     out  1   one-cycle response pulse
// - usb_rsp_data      out  32  response data
// - busy              out  1   FSM not in IDLE
// - stat_pcie_cnt     out  16  host grant count
// - stat_usb_cnt      out  16  USB grant count
// - stat_ur_cnt       out  16  UR completion count
// BEHAVIOUR
// - Reset (async assert, sync release): FSM = IDLE, starve_cnt = 0; every output = 0 (including ready and stat counters).
// - FSM states: IDLE -> ISSUE -> [WAIT] -> CPL | URSP -> IDLE.
// - IDLE, arbitration:
//   - grant = USB if usb_req_valid & (!pcie_req_valid | starve_cnt == STARVE_LIMIT); else host if pcie_req_valid.
//   - Only the granted requester sees ready = 1 (combinational, IDLE only).
//   - On handshake, register all request fields, the requester id, and ur = host & !func_mask[func].
// - starve_cnt: +1 on each host grant while usb_req_valid = 1; cleared on USB grant or when usb_req_valid = 0 in IDLE.
// - ISSUE (1 cycle):
//   - mem_en = 1 with registered fields, unless ur = 1.
//   - USB access to a masked function: memory is still accessed; the mask applies to host traffic only.
//   - Next state:
//     - read & !ur -> WAIT
//     - host write or ur -> CPL
//     - USB write -> URSP
// - WAIT: counts MEM_RD_LATENCY-1 cycles, then captures mem_rdata; next CPL (host) or URSP (USB).
// - CPL: cpl_valid held with stable fields until cpl_ready; then IDLE.
//   - cpl_data = captured data for SC reads, 0 for writes and UR.
//   - cpl_status = 001 iff ur.
// - URSP: usb_rsp_valid = 1 for exactly one cycle; usb_rsp_data = read data, or 0 for writes; next IDLE.
// - Latency, handshake at cycle 0:
//   - host read: cpl_valid first at cycle MEM_RD_LATENCY+2;
//   - host write or UR: cycle 2;
//   - USB read: usb_rsp_valid at MEM_RD_LATENCY+2;
//   - USB write: cycle 2.
// - Throughput: no new handshake while busy; back-to-back accesses are separated by at least one IDLE cycle.
// - Simultaneous valid in IDLE: host wins unless starve_cnt == STARVE_LIMIT.
// - cpl_ready held low: FSM stalls in CPL; both ready outputs stay 0; no requests are dropped.
// - Reset mid-access: pending access and completion are discarded; the memory may already hold a written value.
// - func_mask changes are sampled only at handshake.
// - Counters saturate at 16'hFFFF.
// CONFIGURATION
// - CFG_ARB_STATS_EN defined:
//   - stat_pcie_cnt increments on each host grant;
//   - stat_usb_cnt increments on each USB grant;
//   - stat_ur_cnt increments on each UR completion accepted.
// - CFG_ARB_STATS_EN undefined: all three stat outputs are constant 0 and the counter logic is absent.
// TESTING
// - Host CfgRd func 0, addr 0x001, mem returns 0x0010_0007 -> cpl_valid at cycle 4 (L = 2); status 000, data 0x0010_0007, tag/reqid echoed.
// - Host CfgWr func 5 with func_mask = 0x01 -> no mem_en; cpl at cycle 2, status 001, tlpwr 1, data 0; stat_ur_cnt = 1 (stats on).
// - Both valid continuously, STARVE_LIMIT = 4 -> grant order H, H, H, H, U, H, ...; starve_cnt cleared after the U grant.
// - cpl_ready low 10 cycles after a host read -> cpl fields stable, both readies 0; on cpl_ready = 1 the next grant occurs after one IDLE cycle.
// - USB write then USB read of func 2, addr 0x3FF, data 0xDEAD_BEEF, be 4'hF -> usb_rsp pulses data 0, then 0xDEAD_BEEF; no cpl_valid.
// - rst_n asserted during WAIT -> all outputs 0 immediately; after release a new host read completes normally.

Source files
------------

// File: rtl/pcileech_cfg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_cfg_access_arbiter
// Purpose  : Arbitrates the shared multi-function config-space memory port
//            between decoded host CfgRd/CfgWr requests and FPGA-side (USB /
//            shadow) accesses. One access in flight at a time. Host accesses
//            return a completion record; USB accesses return a one-cycle
//            response pulse. Host requests to unimplemented functions are
//            answered with UR and never touch memory.
// Options  : CFG_ARB_STATS_EN - when defined, grant and UR statistics
//            counters are built; otherwise the stat outputs are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pcileech_cfg_access_arbiter #(
  parameter int unsigned MEM_RD_LATENCY = 2,  // 1..7
  parameter int unsigned STARVE_LIMIT   = 4   // 1..15
) (
  input  logic        clk_pcie,
  input  logic        rst_n,
  // host request
  input  logic        pcie_req_valid,
  output logic        pcie_req_ready,
  input  logic        pcie_req_wr,
  input  logic [2:0]  pcie_req_func,
  input  logic [9:0]  pcie_req_addr,
  input  logic [3:0]  pcie_req_be,
  input  logic [31:0] pcie_req_data,
  input  logic [7:0]  pcie_req_tag,
  input  logic [15:0] pcie_req_reqid,
  // USB request
  input  logic        usb_req_valid,
  output logic        usb_req_ready,
  input  logic        usb_req_wr,
  input  logic [2:0]  usb_req_func,
  input  logic [9:0]  usb_req_addr,
  input  logic [3:0]  usb_req_be,
  input  logic [31:0] usb_req_data,
  input  logic [7:0]  func_mask,
  // memory port
  output logic        mem_en,
  output logic        mem_wr,
  output logic [2:0]  mem_func,
  output logic [9:0]  mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // host completion
  output logic        cpl_valid,
  input  logic        cpl_ready,
  output logic [2:0]  cpl_status,
  output logic        cpl_tlpwr,
  output logic [7:0]  cpl_tag,
  output logic [15:0] cpl_reqid,
  output logic [31:0] cpl_data,
  // USB response
  output logic        usb_rsp_valid,
  output logic [31:0] usb_rsp_data,
  // status
  output logic        busy,
  output logic [15:0] stat_pcie_cnt,
  output logic [15:0] stat_usb_cnt,
  output logic [15:0] stat_ur_cnt
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_ISSUE = 3'd1;
  localparam logic [2:0] c_ST_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_CPL   = 3'd3;
  localparam logic [2:0] c_ST_URSP  = 3'd4;

  localparam logic [2:0] c_WAIT_LAST  = 3'(MEM_RD_LATENCY - 1);
  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

  logic [2:0]  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        run_q;
  logic        usb_q, wr_q, ur_q;
  logic [2:0]  func_q;
  logic [9:0]  addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [7:0]  tag_q;
  logic [15:0] reqid_q;
  logic [31:0] rdata_q;
  logic [2:0]  wait_cnt_q;

  logic w_idle, w_grant_usb, w_grant_pcie, w_hs_pcie, w_hs_usb, w_wait_done;

  // USB wins only when the host is silent or has starved it long enough.
  assign w_idle       = (state_q == c_ST_IDLE);
  assign w_grant_usb  = usb_req_valid & (~pcie_req_valid | (starve_q == c_STARVE_MAX));
  assign w_grant_pcie = pcie_req_valid & ~w_grant_usb;
  assign w_hs_pcie    = pcie_req_valid & pcie_req_ready;
  assign w_hs_usb     = usb_req_valid & usb_req_ready;
  assign w_wait_done  = (wait_cnt_q == c_WAIT_LAST);

  // State register, starvation counter and post-reset run flag.
  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= c_ST_IDLE;
      starve_q <= 4'd0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      run_q    <= 1'b1;
    end
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:  if (w_hs_pcie | w_hs_usb) state_d = c_ST_ISSUE;
      c_ST_ISSUE: begin
        if (ur_q)       state_d = c_ST_CPL;
        else if (!wr_q) state_d = c_ST_WAIT;
        else if (usb_q) state_d = c_ST_URSP;
        else            state_d = c_ST_CPL;
      end
      c_ST_WAIT:  if (w_wait_done) state_d = usb_q ? c_ST_URSP : c_ST_CPL;
      c_ST_CPL:   if (cpl_ready) state_d = c_ST_IDLE;
      c_ST_URSP:  state_d = c_ST_IDLE;
      default:    state_d = c_ST_IDLE;
    endcase
  end

  // Starvation tracking: counts host grants taken while USB was waiting.
  always_comb begin
    starve_d = starve_q;
    if (w_idle) begin
      if (w_hs_usb)                        starve_d = 4'd0;
      else if (w_hs_pcie && usb_req_valid) starve_d = starve_q + 4'd1;
      else if (!usb_req_valid)             starve_d = 4'd0;
    end
  end

  // Outputs decoded from the current state; fields are zero when not valid.
  always_comb begin
    pcie_req_ready = w_idle & run_q & w_grant_pcie;
    usb_req_ready  = w_idle & run_q & w_grant_usb;
    busy           = ~w_idle;
    mem_en         = 1'b0;
    mem_wr         = 1'b0;
    mem_func       = 3'd0;
    mem_addr       = 10'd0;
    mem_be         = 4'd0;
    mem_wdata      = 32'd0;
    cpl_valid      = 1'b0;
    cpl_status     = 3'd0;
    cpl_tlpwr      = 1'b0;
    cpl_tag        = 8'd0;
    cpl_reqid      = 16'd0;
    cpl_data       = 32'd0;
    usb_rsp_valid  = 1'b0;
    usb_rsp_data   = 32'd0;
    case (state_q)
      c_ST_ISSUE: begin
        if (!ur_q) begin
          mem_en    = 1'b1;
          mem_wr    = wr_q;
          mem_func  = func_q;
          mem_addr  = addr_q;
          mem_be    = be_q;
          mem_wdata = wdata_q;
        end
      end
      c_ST_CPL: begin
        cpl_valid  = 1'b1;
        cpl_status = {2'b00, ur_q};
        cpl_tlpwr  = wr_q;
        cpl_tag    = tag_q;
        cpl_reqid  = reqid_q;
        cpl_data   = rdata_q;
      end
      c_ST_URSP: begin
        usb_rsp_valid = 1'b1;
        usb_rsp_data  = rdata_q;
      end
      default: ;
    endcase
  end

  // Capture the granted request and the read data; rdata stays 0 for writes/UR.
  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      usb_q      <= 1'b0;
      wr_q       <= 1'b0;
      ur_q       <= 1'b0;
      func_q     <= 3'd0;
      addr_q     <= 10'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      tag_q      <= 8'd0;
      reqid_q    <= 16'd0;
      rdata_q    <= 32'd0;
      wait_cnt_q <= 3'd0;
    end else if (w_hs_pcie || w_hs_usb) begin
      usb_q      <= w_hs_usb;
      wr_q       <= w_hs_usb ? usb_req_wr   : pcie_req_wr;
      func_q     <= w_hs_usb ? usb_req_func : pcie_req_func;
      addr_q     <= w_hs_usb ? usb_req_addr : pcie_req_addr;
      be_q       <= w_hs_usb ? usb_req_be   : pcie_req_be;
      wdata_q    <= w_hs_usb ? usb_req_data : pcie_req_data;
      tag_q      <= w_hs_usb ? 8'd0         : pcie_req_tag;
      reqid_q    <= w_hs_usb ? 16'd0        : pcie_req_reqid;
      ur_q       <= w_hs_pcie & ~func_mask[pcie_req_func];
      rdata_q    <= 32'd0;
      wait_cnt_q <= 3'd0;
    end else if (state_q == c_ST_WAIT) begin
      if (w_wait_done) rdata_q <= mem_rdata;
      else             wait_cnt_q <= wait_cnt_q + 3'd1;
    end
  end

`ifdef CFG_ARB_STATS_EN
  logic [15:0] stat_pcie_q, stat_usb_q, stat_ur_q;

  // Saturating grant / UR statistics.
  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      stat_pcie_q <= 16'd0;
      stat_usb_q  <= 16'd0;
      stat_ur_q   <= 16'd0;
    end else begin
      if (w_hs_pcie && stat_pcie_q != 16'hFFFF) stat_pcie_q <= stat_pcie_q + 16'd1;
      if (w_hs_usb  && stat_usb_q  != 16'hFFFF) stat_usb_q  <= stat_usb_q + 16'd1;
      if ((state_q == c_ST_CPL) && cpl_ready && ur_q && stat_ur_q != 16'hFFFF)
        stat_ur_q <= stat_ur_q + 16'd1;
    end
  end

  assign stat_pcie_cnt = stat_pcie_q;
  assign stat_usb_cnt  = stat_usb_q;
  assign stat_ur_cnt   = stat_ur_q;
`else
  assign stat_pcie_cnt = 16'd0;
  assign stat_usb_cnt  = 16'd0;
  assign stat_ur_cnt   = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcileech_cfg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcileech_cfg_access_arbiter
// Purpose  : Directed self-checking bench for pcileech_cfg_access_arbiter
//            with MEM_RD_LATENCY = 2 and STARVE_LIMIT = 4. A small byte-
//            enabled memory model answers reads after two cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcileech_cfg_access_arbiter;

  logic        clk_pcie = 1'b0;
  logic        rst_n;
  logic        pcie_req_valid, pcie_req_ready, pcie_req_wr;
  logic [2:0]  pcie_req_func;
  logic [9:0]  pcie_req_addr;
  logic [3:0]  pcie_req_be;
  logic [31:0] pcie_req_data;
  logic [7:0]  pcie_req_tag;
  logic [15:0] pcie_req_reqid;
  logic        usb_req_valid, usb_req_ready, usb_req_wr;
  logic [2:0]  usb_req_func;
  logic [9:0]  usb_req_addr;
  logic [3:0]  usb_req_be;
  logic [31:0] usb_req_data;
  logic [7:0]  func_mask;
  logic        mem_en, mem_wr;
  logic [2:0]  mem_func;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        cpl_valid, cpl_ready, cpl_tlpwr;
  logic [2:0]  cpl_status;
  logic [7:0]  cpl_tag;
  logic [15:0] cpl_reqid;
  logic [31:0] cpl_data;
  logic        usb_rsp_valid;
  logic [31:0] usb_rsp_data;
  logic        busy;
  logic [15:0] stat_pcie_cnt, stat_usb_cnt, stat_ur_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  pcileech_cfg_access_arbiter #(.MEM_RD_LATENCY(2), .STARVE_LIMIT(4)) dut (
    .clk_pcie(clk_pcie), .rst_n(rst_n),
    .pcie_req_valid(pcie_req_valid), .pcie_req_ready(pcie_req_ready),
    .pcie_req_wr(pcie_req_wr), .pcie_req_func(pcie_req_func),
    .pcie_req_addr(pcie_req_addr), .pcie_req_be(pcie_req_be),
    .pcie_req_data(pcie_req_data), .pcie_req_tag(pcie_req_tag),
    .pcie_req_reqid(pcie_req_reqid),
    .usb_req_valid(usb_req_valid), .usb_req_ready(usb_req_ready),
    .usb_req_wr(usb_req_wr), .usb_req_func(usb_req_func),
    .usb_req_addr(usb_req_addr), .usb_req_be(usb_req_be),
    .usb_req_data(usb_req_data), .func_mask(func_mask),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_func(mem_func), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_status(cpl_status),
    .cpl_tlpwr(cpl_tlpwr), .cpl_tag(cpl_tag), .cpl_reqid(cpl_reqid),
    .cpl_data(cpl_data), .usb_rsp_valid(usb_rsp_valid),
    .usb_rsp_data(usb_rsp_data), .busy(busy),
    .stat_pcie_cnt(stat_pcie_cnt), .stat_usb_cnt(stat_usb_cnt),
    .stat_ur_cnt(stat_ur_cnt)
  );

  always #5 clk_pcie = ~clk_pcie;

  // Memory model: 8 functions x 1024 DWORDs, read data valid 2 cycles after mem_en.
  logic [31:0] mem [0:8191];
  logic [31:0] rd_p0 = 32'd0;
  logic [31:0] rd_p1 = 32'd0;
  assign mem_rdata = rd_p1;

  always @(posedge clk_pcie) begin
    rd_p0 <= (mem_en && !mem_wr) ? mem[{mem_func, mem_addr}] : 32'd0;
    rd_p1 <= rd_p0;
    if (mem_en && mem_wr) begin
      if (mem_be[0]) mem[{mem_func, mem_addr}][7:0]   = mem_wdata[7:0];
      if (mem_be[1]) mem[{mem_func, mem_addr}][15:8]  = mem_wdata[15:8];
      if (mem_be[2]) mem[{mem_func, mem_addr}][23:16] = mem_wdata[23:16];
      if (mem_be[3]) mem[{mem_func, mem_addr}][31:24] = mem_wdata[31:24];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pcie);
    #1;
  endtask

  // Present a host request, confirm the grant, leave the bench in cycle 1.
  task automatic host_go(input logic wr, input logic [2:0] f, input logic [9:0] a,
                         input logic [3:0] be, input logic [31:0] d,
                         input logic [7:0] tg, input logic [15:0] rid);
    pcie_req_wr = wr; pcie_req_func = f; pcie_req_addr = a; pcie_req_be = be;
    pcie_req_data = d; pcie_req_tag = tg; pcie_req_reqid = rid;
    pcie_req_valid = 1'b1;
    #1;
    check_eq("host_ready", pcie_req_ready, 1'b1);
    tick();
    pcie_req_valid = 1'b0;
  endtask

  task automatic usb_go(input logic wr, input logic [2:0] f, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    usb_req_wr = wr; usb_req_func = f; usb_req_addr = a; usb_req_be = be;
    usb_req_data = d; usb_req_valid = 1'b1;
    #1;
    check_eq("usb_ready", {pcie_req_ready, usb_req_ready}, 2'b01);
    tick();
    usb_req_valid = 1'b0;
  endtask

  // Bounded wait for cpl_valid / usb_rsp_valid; returns the cycle index (handshake = 0).
  task automatic wait_evt(input bit is_usb, output int lat);
    lat = 1;
    while (((is_usb ? usb_rsp_valid : cpl_valid) !== 1'b1) && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int grants;
    int cyc;
    logic [10:0] seq;

    for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
    mem[{3'd0, 10'd1}] = 32'h0010_0007;

    rst_n = 1'b0; cpl_ready = 1'b1; func_mask = 8'h01;
    pcie_req_valid = 1'b1; pcie_req_wr = 1'b0; pcie_req_func = 3'd0; pcie_req_addr = 10'd0;
    pcie_req_be = 4'hF; pcie_req_data = 32'd0; pcie_req_tag = 8'd0; pcie_req_reqid = 16'd0;
    usb_req_valid = 1'b1; usb_req_wr = 1'b0; usb_req_func = 3'd0; usb_req_addr = 10'd0;
    usb_req_be = 4'hF; usb_req_data = 32'd0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_readies", {pcie_req_ready, usb_req_ready}, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_outs", {cpl_valid, mem_en, usb_rsp_valid}, 3'b000);
    check_eq("rst_stats", {stat_pcie_cnt, stat_ur_cnt}, 32'd0);
    check_eq("rst_stat_usb", stat_usb_cnt, 16'd0);
    pcie_req_valid = 1'b0; usb_req_valid = 1'b0;
    rst_n = 1'b1;
    tick(); tick();

    // Host CfgRd func 0 addr 1
    host_go(1'b0, 3'd0, 10'h001, 4'hF, 32'd0, 8'h5A, 16'h1234);
    check_eq("rd_mem_en", {mem_en, mem_wr}, 2'b10);
    check_eq("rd_mem_addr", {mem_func, mem_addr}, {3'd0, 10'h001});
    check_eq("rd_busy", busy, 1'b1);
    wait_evt(1'b0, lat);
    check_eq("rd_lat", lat, 4);
    check_eq("rd_status", cpl_status, 3'b000);
    check_eq("rd_data", cpl_data, 32'h0010_0007);
    check_eq("rd_tag_reqid", {cpl_tag, cpl_reqid}, {8'h5A, 16'h1234});
    check_eq("rd_tlpwr", cpl_tlpwr, 1'b0);
    tick();
    check_eq("rd_idle", busy, 1'b0);

    // Host CfgWr to unimplemented func 5 -> UR, no memory access
    host_go(1'b1, 3'd5, 10'h010, 4'hF, 32'h1111_2222, 8'h21, 16'hABCD);
    check_eq("ur_no_mem", mem_en, 1'b0);
    wait_evt(1'b0, lat);
    check_eq("ur_lat", lat, 2);
    check_eq("ur_status", cpl_status, 3'b001);
    check_eq("ur_tlpwr", cpl_tlpwr, 1'b1);
    check_eq("ur_data", cpl_data, 32'd0);
    check_eq("ur_tag", cpl_tag, 8'h21);
    tick();
`ifdef CFG_ARB_STATS_EN
    check_eq("ur_stat_ur", stat_ur_cnt, 16'd1);
    check_eq("ur_stat_pcie", stat_pcie_cnt, 16'd2);
`else
    check_eq("ur_stat_ur", stat_ur_cnt, 16'd0);
    check_eq("ur_stat_pcie", stat_pcie_cnt, 16'd0);
`endif

    // Host SC write with partial byte enables, then read back
    host_go(1'b1, 3'd0, 10'h002, 4'b0011, 32'hCAFE_F00D, 8'h30, 16'h0001);
    check_eq("wr_mem", {mem_en, mem_wr, mem_be}, {2'b11, 4'b0011});
    check_eq("wr_wdata", mem_wdata, 32'hCAFE_F00D);
    wait_evt(1'b0, lat);
    check_eq("wr_lat", lat, 2);
    check_eq("wr_cpl", {cpl_status, cpl_tlpwr}, {3'b000, 1'b1});
    check_eq("wr_data", cpl_data, 32'd0);
    tick();
    host_go(1'b0, 3'd0, 10'h002, 4'hF, 32'd0, 8'h31, 16'h0001);
    wait_evt(1'b0, lat);
    check_eq("rb_lat", lat, 4);
    check_eq("rb_data", cpl_data, 32'h0000_F00D);
    tick();

    // USB write then read of masked func 2, addr 0x3FF
    usb_go(1'b1, 3'd2, 10'h3FF, 4'hF, 32'hDEAD_BEEF);
    check_eq("uw_mem", {mem_en, mem_wr, mem_func, mem_addr}, {2'b11, 3'd2, 10'h3FF});
    wait_evt(1'b1, lat);
    check_eq("uw_lat", lat, 2);
    check_eq("uw_data", usb_rsp_data, 32'd0);
    check_eq("uw_no_cpl", cpl_valid, 1'b0);
    tick();
    check_eq("uw_pulse", {usb_rsp_valid, busy}, 2'b00);
    usb_go(1'b0, 3'd2, 10'h3FF, 4'hF, 32'd0);
    wait_evt(1'b1, lat);
    check_eq("ur_rd_lat", lat, 4);
    check_eq("ur_rd_data", usb_rsp_data, 32'hDEAD_BEEF);
    check_eq("ur_rd_no_cpl", cpl_valid, 1'b0);
    tick();
    check_eq("ur_rd_pulse", usb_rsp_valid, 1'b0);

    // Both requesters valid continuously: H H H H U H H H H U H
    pcie_req_wr = 1'b0; pcie_req_func = 3'd0; pcie_req_addr = 10'h001; pcie_req_tag = 8'h40;
    usb_req_wr = 1'b0; usb_req_func = 3'd2; usb_req_addr = 10'h3FF;
    pcie_req_valid = 1'b1; usb_req_valid = 1'b1;
    #1;
    grants = 0; cyc = 0; seq = '0;
    while (grants < 11 && cyc < 400) begin
      if (pcie_req_ready) begin seq[grants] = 1'b0; grants++; end
      else if (usb_req_ready) begin seq[grants] = 1'b1; grants++; end
      tick();
      cyc++;
    end
    check_eq("starve_grants", grants, 11);
    check_eq("starve_seq", seq, 11'h210);
    pcie_req_valid = 1'b0; usb_req_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin tick(); cyc++; end
    check_eq("starve_drain", busy, 1'b0);

    // Completion back-pressure: FSM holds in CPL with stable fields
    cpl_ready = 1'b0;
    host_go(1'b0, 3'd0, 10'h001, 4'hF, 32'd0, 8'h77, 16'h4321);
    wait_evt(1'b0, lat);
    check_eq("stall_lat", lat, 4);
    pcie_req_tag = 8'h88; pcie_req_valid = 1'b1; usb_req_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_valid", cpl_valid, 1'b1);
      check_eq("stall_fields", {cpl_tag, cpl_reqid}, {8'h77, 16'h4321});
      check_eq("stall_data", cpl_data, 32'h0010_0007);
      check_eq("stall_readies", {pcie_req_ready, usb_req_ready}, 2'b00);
      tick();
    end
    pcie_req_valid = 1'b0;
    cpl_ready = 1'b1;
    tick();
    check_eq("stall_idle", {busy, cpl_valid}, 2'b00);
    check_eq("stall_next_grant", usb_req_ready, 1'b1);
    tick();
    usb_req_valid = 1'b0;
    wait_evt(1'b1, lat);
    check_eq("stall_usb_lat", lat, 4);
    check_eq("stall_usb_data", usb_rsp_data, 32'hDEAD_BEEF);
    tick();

    // Reset asserted during WAIT
    host_go(1'b0, 3'd0, 10'h001, 4'hF, 32'd0, 8'h99, 16'h5555);
    tick();
    check_eq("mid_busy", busy, 1'b1);
    rst_n = 1'b0; pcie_req_valid = 1'b1;
    #1;
    check_eq("mid_rst_outs", {busy, mem_en, cpl_valid, usb_rsp_valid}, 4'b0000);
    check_eq("mid_rst_ready", {pcie_req_ready, usb_req_ready}, 2'b00);
    tick(); tick();
    check_eq("mid_rst_no_cpl", cpl_valid, 1'b0);
    pcie_req_valid = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    host_go(1'b0, 3'd0, 10'h001, 4'hF, 32'd0, 8'h9A, 16'h5555);
    wait_evt(1'b0, lat);
    check_eq("post_rst_lat", lat, 4);
    check_eq("post_rst_data", cpl_data, 32'h0010_0007);
    check_eq("post_rst_tag", cpl_tag, 8'h9A);
    tick();
`ifdef CFG_ARB_STATS_EN
    check_eq("end_stats", {stat_pcie_cnt, stat_usb_cnt}, {16'd1, 16'd0});
`else
    check_eq("end_stats", {stat_pcie_cnt, stat_usb_cnt}, 32'd0);
`endif
    check_eq("end_stat_ur", stat_ur_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
